bram_port_req_ctrl: RTL and testbench

Request/response front-end for one port of the single-clock true dual-port write-first BRAM.
- Accepts valid/ready read and write requests from a client and drives the BRAM port signals (en, we, addr, din, regce, rst).
- Tracks in-flight reads across the BRAM read latency and captures read data into a response FIFO.
- A credit check guarantees every issued read has a FIFO slot, so response back-pressure never loses data.
- One instance is placed per BRAM port.

---
 rtl/bram_port_req_ctrl.sv | 137 +++++++++++++
 tb/tb_bram_port_req_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_req_ctrl.sv
// bram_port_req_ctrl
//   Request/response front-end for one port of a single-clock, write-first,
//   true dual-port BRAM. Client valid/ready requests are forwarded
//   combinationally to the BRAM port. Reads are tracked across the BRAM read
//   latency, and their data lands in a small response FIFO. Issue is gated by
//   a credit count, so every read already owns a FIFO slot when it fires.
//
// Ports
//   clka, rstb          clock shared with the BRAM; synchronous active-high reset
//   req_*               client request (we=1 write, we=0 read)
//   rsp_*               read responses, returned in request order
//   bram_*              BRAM port: en/we/addr/din/regce/rst out, dout in
//   rd_pending          reads in flight plus responses queued
module bram_port_req_ctrl #(
  parameter int DATA_W    = 18,
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                             clka,
  input  logic                             rstb,
  input  logic                             req_val,
  output logic                             req_rdy,
  input  logic                             req_we,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [DATA_W-1:0]                req_wdata,
  output logic                             rsp_val,
  input  logic                             rsp_rdy,
  output logic [DATA_W-1:0]                rsp_rdata,
  output logic                             bram_en,
  output logic                             bram_we,
  output logic [ADDR_W-1:0]                bram_addr,
  output logic [DATA_W-1:0]                bram_din,
  output logic                             bram_regce,
  output logic                             bram_rst,
  input  logic [DATA_W-1:0]                bram_dout,
  output logic [$clog2(RSP_DEPTH+1)-1:0]   rd_pending
);

  localparam int CNT_W = $clog2(RSP_DEPTH+1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH-1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("bram_port_req_ctrl: READ_LAT must be 1 or 2");
  end

  logic                             fire, rd_fire, push, pop;
  logic [READ_LAT-1:0]              vld_pipe;
  logic [RSP_DEPTH-1:0][DATA_W-1:0] fifo_mem;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic [CNT_W-1:0]                 fifo_cnt, pend_cnt;

  // Credit check: pend_cnt counts every slot a read may still need. Writes
  // are gated by it too, which keeps the ready independent of req_we.
  assign req_rdy    = !rstb && (pend_cnt < DEPTH_C);
  assign fire       = req_val & req_rdy;
  assign rd_fire    = fire & ~req_we;
  assign push       = vld_pipe[READ_LAT-1];
  assign pop        = rsp_val & rsp_rdy;

  assign bram_en    = fire;
  assign bram_we    = fire & req_we;
  assign bram_addr  = req_addr;
  assign bram_din   = req_wdata;
  assign bram_rst   = rstb;

  assign rsp_val    = (fifo_cnt != '0);
  assign rsp_rdata  = fifo_mem[rd_ptr];
  assign rd_pending = pend_cnt;

  // Read-valid pipeline, one stage per cycle of BRAM latency. The output
  // register is enabled only in the cycle that read data reaches it.
  if (READ_LAT == 1) begin : g_lat1
    assign bram_regce = 1'b1;
    always_ff @(posedge clka) begin
      if (rstb) vld_pipe <= '0;
      else      vld_pipe <= rd_fire;
    end
  end else begin : g_latn
    assign bram_regce = vld_pipe[0];
    always_ff @(posedge clka) begin
      if (rstb) vld_pipe <= '0;
      else      vld_pipe <= {vld_pipe[READ_LAT-2:0], rd_fire};
    end
  end

  // Response FIFO. The storage is cleared on reset so the head reads 0.
  // The pointers wrap explicitly, so the depth need not be a power of two.
  always_ff @(posedge clka) begin
    if (rstb) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bram_dout;
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
      end
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (rstb) pend_cnt <= '0;
    else begin
      case ({rd_fire, pop})
        2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
        2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  // Safety net: the credit gate should make all of these unreachable.
  always_ff @(posedge clka) begin
    if (!rstb) begin
      assert (!(rd_fire && !pop && pend_cnt == DEPTH_C))
        else $error("rd_pending overflow");
      assert (!(pop && !rd_fire && pend_cnt == '0))
        else $error("rd_pending underflow");
      assert (!(push && !pop && fifo_cnt == DEPTH_C))
        else $error("response FIFO overflow");
    end
  end

endmodule

// File: tb/tb_bram_port_req_ctrl.sv
// Bench for bram_port_req_ctrl. It drives two instances: one with READ_LAT=2
// and one with READ_LAT=1. Each instance sits on its own BRAM model. Each read
// fire pushes an expected {data, cycle} onto a scoreboard queue, and each
// response pop is compared against the queue head.
module tb_bram_port_req_ctrl;

  logic        clka = 1'b0;
  logic        rstb = 1'b1;
  logic        req_val = 1'b0, req_we = 1'b0, rsp_rdy = 1'b1, use1 = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [17:0] req_wdata = '0;
  int          cyc = 0, checks = 0, errors = 0, stalls = 0;
  int          nrsp1 = 0, nrsp2 = 0;

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  typedef struct { logic [17:0] data; int cyc; bit lat; } sb_t;
  sb_t q1[$], q2[$];
  logic [17:0] ref1 [1024];
  logic [17:0] ref2 [1024];

  // ---------------- READ_LAT=2 instance + BRAM model ----------------
  logic        val2, rdy2, rsp_val2, en2, we2, regce2, brst2;
  logic [9:0]  addr2;
  logic [17:0] rsp_rdata2, din2, dout2, ramq2;
  logic [2:0]  pend2;
  logic [17:0] mem2 [1024];
  assign val2 = req_val & ~use1;

  bram_port_req_ctrl #(.DATA_W(18), .ADDR_W(10), .READ_LAT(2), .RSP_DEPTH(4)) dut (
    .clka(clka), .rstb(rstb), .req_val(val2), .req_rdy(rdy2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_val(rsp_val2), .rsp_rdy(rsp_rdy),
    .rsp_rdata(rsp_rdata2), .bram_en(en2), .bram_we(we2), .bram_addr(addr2),
    .bram_din(din2), .bram_regce(regce2), .bram_rst(brst2), .bram_dout(dout2),
    .rd_pending(pend2));

  always @(posedge clka) begin
    if (en2) begin
      if (we2) begin mem2[addr2] <= din2; ramq2 <= din2; end
      else ramq2 <= mem2[addr2];
    end
    if (brst2)       dout2 <= '0;
    else if (regce2) dout2 <= ramq2;
  end

  // ---------------- READ_LAT=1 instance + BRAM model ----------------
  logic        val1, rdy1, rsp_val1, en1, we1, regce1, brst1;
  logic [9:0]  addr1;
  logic [17:0] rsp_rdata1, din1, ramq1;
  logic [2:0]  pend1;
  logic [17:0] mem1 [1024];
  assign val1 = req_val & use1;

  bram_port_req_ctrl #(.DATA_W(18), .ADDR_W(10), .READ_LAT(1), .RSP_DEPTH(4)) dut1 (
    .clka(clka), .rstb(rstb), .req_val(val1), .req_rdy(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_val(rsp_val1), .rsp_rdy(rsp_rdy),
    .rsp_rdata(rsp_rdata1), .bram_en(en1), .bram_we(we1), .bram_addr(addr1),
    .bram_din(din1), .bram_regce(regce1), .bram_rst(brst1), .bram_dout(ramq1),
    .rd_pending(pend1));

  always @(posedge clka) begin
    if (en1) begin
      if (we1) begin mem1[addr1] <= din1; ramq1 <= din1; end
      else ramq1 <= mem1[addr1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitors: pop before push, so a fire is never matched in its own cycle.
  always @(negedge clka) begin
    sb_t e;
    if (rstb) q2.delete();
    else begin
      if (rsp_val2 && rsp_rdy) begin
        nrsp2++;
        if (q2.size() == 0) chk("stale_rsp2", 32'(rsp_val2), 32'd0);
        else begin
          e = q2.pop_front();
          chk("rdata2", 32'(rsp_rdata2), 32'(e.data));
          if (e.lat) chk("lat2", 32'(cyc - e.cyc), 32'd3);
        end
      end
      if (val2 && rdy2) begin
        if (req_we) ref2[req_addr] = req_wdata;
        else q2.push_back('{ref2[req_addr], cyc, rsp_rdy});
      end
    end
  end

  always @(negedge clka) begin
    sb_t e;
    if (rstb) q1.delete();
    else begin
      if (rsp_val1 && rsp_rdy) begin
        nrsp1++;
        if (q1.size() == 0) chk("stale_rsp1", 32'(rsp_val1), 32'd0);
        else begin
          e = q1.pop_front();
          chk("rdata1", 32'(rsp_rdata1), 32'(e.data));
          if (e.lat) chk("lat1", 32'(cyc - e.cyc), 32'd2);
        end
      end
      if (val1 && rdy1) begin
        chk("regce1", 32'(regce1), 32'd1);
        if (req_we) ref1[req_addr] = req_wdata;
        else q1.push_back('{ref1[req_addr], cyc, rsp_rdy});
      end
    end
  end

  // Present one request and hold it until accepted. The call starts and
  // returns 1ns after a rising edge.
  task automatic send(input bit u, input bit we, input logic [9:0] a, input logic [17:0] d);
    int n = 0;
    use1 = u; req_val = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clka);
    while (!(u ? rdy1 : rdy2)) begin
      stalls++; n++;
      if (n > 200) begin chk("rdy_timeout", 32'(n), 32'd0); break; end
      @(negedge clka);
    end
    @(posedge clka); #1;
  endtask

  task automatic idle(input int k);
    req_val = 1'b0;
    repeat (k) @(posedge clka);
    #1;
  endtask

  initial begin
    int n0, s0, nf;
    // Reset: a pending request must not reach the BRAM.
    req_val = 1'b1; req_we = 1'b1;
    @(negedge clka);
    chk("rst_rdy", 32'(rdy2), 32'd0);
    chk("rst_en", 32'(en2), 32'd0);
    chk("rst_bram_rst", 32'(brst2), 32'd1);
    chk("rst_rsp_val", 32'(rsp_val2), 32'd0);
    chk("rst_pend", 32'(pend2), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata2), 32'd0);
    req_val = 1'b0;
    @(posedge clka); #1 rstb = 1'b0;
    @(negedge clka);
    chk("post_rst_rdy", 32'(rdy2), 32'd1);
    @(posedge clka); #1;

    // 1: write then read one address
    n0 = nrsp2;
    send(0, 1, 10'h005, 18'h2A5A3);
    send(0, 0, 10'h005, 18'h0);
    idle(6);
    chk("t1_nrsp", 32'(nrsp2 - n0), 32'd1);

    // 2: preload 1..8, then back-to-back reads
    for (int a = 1; a <= 8; a++) send(0, 1, 10'(a), 18'(32'h100 + a));
    idle(1);
    s0 = stalls; n0 = nrsp2;
    for (int a = 1; a <= 8; a++) send(0, 0, 10'(a), 18'h0);
    idle(6);
    chk("t2_stalls", 32'(stalls - s0), 32'd0);
    chk("t2_nrsp", 32'(nrsp2 - n0), 32'd8);

    // 3: response back-pressure fills credits
    rsp_rdy = 1'b0; n0 = nrsp2; nf = 0;
    use1 = 1'b0; req_val = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 10'(1 + i);
      @(negedge clka);
      if (rdy2) nf++;
      @(posedge clka); #1;
    end
    req_val = 1'b0;
    @(negedge clka);
    chk("t3_fires", 32'(nf), 32'd4);
    chk("t3_rdy_low", 32'(rdy2), 32'd0);
    chk("t3_pend_full", 32'(pend2), 32'd4);
    @(posedge clka); #1 rsp_rdy = 1'b1;
    idle(6);
    chk("t3_nrsp", 32'(nrsp2 - n0), 32'd4);
    chk("t3_rdy_back", 32'(rdy2), 32'd1);
    chk("t3_pend_zero", 32'(pend2), 32'd0);

    // 4: interleaved writes and reads to one address
    n0 = nrsp2;
    send(0, 1, 10'h010, 18'h1);
    send(0, 0, 10'h010, 18'h0);
    send(0, 1, 10'h010, 18'h2);
    send(0, 0, 10'h010, 18'h0);
    idle(6);
    chk("t4_nrsp", 32'(nrsp2 - n0), 32'd2);

    // 5: reset with 1 response queued and 2 reads in flight
    rsp_rdy = 1'b0;
    send(0, 0, 10'd1, 18'h0);
    send(0, 0, 10'd2, 18'h0);
    send(0, 0, 10'd3, 18'h0);
    req_val = 1'b0; rstb = 1'b1;
    @(negedge clka);
    chk("t5_pre_pend", 32'(pend2), 32'd3);
    chk("t5_pre_val", 32'(rsp_val2), 32'd1);
    @(posedge clka); #1 rstb = 1'b0;
    @(negedge clka);
    chk("t5_rsp_val", 32'(rsp_val2), 32'd0);
    chk("t5_pend", 32'(pend2), 32'd0);
    @(posedge clka); #1 rsp_rdy = 1'b1;
    n0 = nrsp2;
    idle(8);
    chk("t5_no_stale", 32'(nrsp2 - n0), 32'd0);
    send(0, 0, 10'd2, 18'h0);
    idle(6);
    chk("t5_persist_nrsp", 32'(nrsp2 - n0), 32'd1);

    // 6: READ_LAT=1 instance, back-to-back reads
    for (int a = 1; a <= 8; a++) send(1, 1, 10'(a), 18'(32'h100 + a));
    idle(1);
    s0 = stalls; n0 = nrsp1;
    for (int a = 1; a <= 8; a++) send(1, 0, 10'(a), 18'h0);
    idle(6);
    chk("t6_stalls", 32'(stalls - s0), 32'd0);
    chk("t6_nrsp", 32'(nrsp1 - n0), 32'd8);
    chk("t6_regce_idle", 32'(regce1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
